// File: rtl/loader_pkg.sv
// Shared types and constants for the ASCII hex word loader.
package loader_pkg;

    localparam int unsigned WORD_SIZE   = 32;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned COUNT_W     = 16;
    localparam int unsigned NIBBLE_W    = 4;
    localparam int unsigned DIGIT_CNT_W = 4;
    localparam int unsigned MAX_DIGITS  = WORD_SIZE / NIBBLE_W;

    localparam logic [7:0] CH_AT  = 8'h40;
    localparam logic [7:0] CH_EOT = 8'h04;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;

    localparam logic [1:0] WRITE_MODE_WORD = 2'b11;
    localparam logic [1:0] WRITE_MODE_IDLE = 2'b00;

    typedef enum logic [2:0] {
        PARSE = 3'd0,
        ADDR  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_e;

    typedef struct packed {
        logic                is_digit;
        logic                is_delim;
        logic                is_at;
        logic                is_eot;
        logic [NIBBLE_W-1:0] nibble;
    } char_class_t;

endpackage

// File: rtl/hex_word_loader_decode.sv
// Classifies one ASCII character; inverse of the nibble-to-ASCII print table.
module ascii_hex_decode
    import loader_pkg::*;
(
    input  logic [7:0]  ascii_data,
    output char_class_t cls_c
);

    always_comb begin
        cls_c = '0;
        if (ascii_data >= 8'h30 && ascii_data <= 8'h39) begin
            cls_c.is_digit = 1'b1;
            cls_c.nibble   = NIBBLE_W'(ascii_data - 8'h30);
        end else if (ascii_data >= 8'h41 && ascii_data <= 8'h46) begin
            cls_c.is_digit = 1'b1;
            cls_c.nibble   = NIBBLE_W'(ascii_data - 8'h37);
        end else if (ascii_data >= 8'h61 && ascii_data <= 8'h66) begin
            cls_c.is_digit = 1'b1;
            cls_c.nibble   = NIBBLE_W'(ascii_data - 8'h57);
        end else begin
            cls_c.is_delim = (ascii_data == CH_SP)  || (ascii_data == CH_TAB) ||
                             (ascii_data == CH_LF)  || (ascii_data == CH_CR);
            cls_c.is_at    = (ascii_data == CH_AT);
            cls_c.is_eot   = (ascii_data == CH_EOT);
        end
    end

endmodule

// File: rtl/hex_word_loader.sv
// Parses an ASCII hex stream ("@addr" directives, words, EOT) into word writes.
module hex_word_loader
    import loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MEM_LIMIT  = 32'h0002_0000,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ascii_valid,
    input  logic [7:0]           ascii_data,
    output logic                 ascii_ready,
    input  logic                 mem_done,
    input  logic                 mem_error,
    output logic [1:0]           write_en,
    output logic [ADDR_W-1:0]    memory_address,
    output logic [WORD_SIZE-1:0] write_word,
    output logic [COUNT_W-1:0]   word_count,
    output logic                 load_done,
    output logic                 load_error
);

    state_e                 state_q, state_d;
    logic [WORD_SIZE-1:0]   acc_q, acc_d;
    logic [DIGIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                   eot_pend_q, eot_pend_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [WORD_SIZE-1:0]   wword_q, wword_d;
    logic [COUNT_W-1:0]     wcount_q, wcount_d;
    logic [1:0]             wen_q, wen_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    char_class_t cls_c;
    logic        accept_c;
    logic        cnt_zero_c;
    logic        cnt_full_c;
    logic        write_ok_c;

    ascii_hex_decode u_decode (
        .ascii_data (ascii_data),
        .cls_c      (cls_c)
    );

    assign accept_c   = ascii_valid && ready_q;
    assign cnt_zero_c = (cnt_q == '0);
    assign cnt_full_c = (cnt_q == DIGIT_CNT_W'(MAX_DIGITS));
    // mem_error dominates a simultaneous mem_done
    assign write_ok_c = (state_q == WRITE) && (addr_q < MEM_LIMIT) && !mem_error && mem_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PARSE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PARSE: begin
                if (accept_c) begin
                    if (cls_c.is_digit) begin
                        if (cnt_full_c) state_d = ERROR;
                    end else if (cls_c.is_delim) begin
                        if (!cnt_zero_c) state_d = WRITE;
                    end else if (cls_c.is_at) begin
                        state_d = cnt_zero_c ? ADDR : ERROR;
                    end else if (cls_c.is_eot) begin
                        state_d = cnt_zero_c ? DONE : WRITE;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            ADDR: begin
                if (accept_c) begin
                    if (cls_c.is_digit) begin
                        if (cnt_full_c) state_d = ERROR;
                    end else if (cls_c.is_delim) begin
                        if (!cnt_zero_c) state_d = PARSE;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            WRITE: begin
                if (addr_q >= MEM_LIMIT || mem_error) begin
                    state_d = ERROR;
                end else if (mem_done) begin
                    state_d = eot_pend_q ? DONE : PARSE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        eot_pend_d = eot_pend_q;
        addr_d     = addr_q;
        wword_d    = wword_q;
        wcount_d   = wcount_q;

        if (accept_c && (state_q == PARSE || state_q == ADDR)) begin
            if (cls_c.is_digit && !cnt_full_c) begin
                acc_d = {acc_q[WORD_SIZE-NIBBLE_W-1:0], cls_c.nibble};
                cnt_d = cnt_q + DIGIT_CNT_W'(1);
            end else if ((cls_c.is_delim || (cls_c.is_eot && state_q == PARSE)) && !cnt_zero_c) begin
                // Short tokens are already zero-extended by the shift-in accumulator
                acc_d = '0;
                cnt_d = '0;
                if (state_q == ADDR) begin
                    addr_d = {acc_q[ADDR_W-1:2], 2'b00};
                end else begin
                    wword_d    = acc_q;
                    eot_pend_d = cls_c.is_eot;
                end
            end
        end

        if (write_ok_c) begin
            addr_d   = addr_q + ADDR_W'(4);
            wcount_d = (wcount_q == '1) ? wcount_q : wcount_q + COUNT_W'(1);
        end

        wen_d   = (state_d == WRITE && addr_d < MEM_LIMIT) ? WRITE_MODE_WORD : WRITE_MODE_IDLE;
        ready_d = (state_d == PARSE) || (state_d == ADDR);
        done_d  = (state_d == DONE);
        err_d   = (state_d == ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            eot_pend_q <= 1'b0;
            addr_q     <= RESET_ADDR;
            wword_q    <= '0;
            wcount_q   <= '0;
            wen_q      <= WRITE_MODE_IDLE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            eot_pend_q <= eot_pend_d;
            addr_q     <= addr_d;
            wword_q    <= wword_d;
            wcount_q   <= wcount_d;
            wen_q      <= wen_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ascii_ready    = ready_q;
    assign write_en       = wen_q;
    assign memory_address = addr_q;
    assign write_word     = wword_q;
    assign word_count     = wcount_q;
    assign load_done      = done_q;
    assign load_error     = err_q;

endmodule
